agh_pwm_csr: RTL

Avalon-MM memory-mapped PWM output block for the HPS lightweight bridge. It is the parametrised successor of the single-register LED control path: a configurable number of output channels, each with its own duty cycle, sharing a common prescaler and period counter. Duty values are double-buffered so that updates never glitch mid-period, and reads use a fixed two-cycle pipeline.

---
 rtl/agh_pwm_csr_if.sv | 31 +++
 rtl/agh_pwm_csr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/agh_pwm_csr_if.sv
// Avalon-MM slave bundle for agh_pwm_csr: the master drives requests, the slave returns data and strobes.
interface agh_pwm_csr_if #(
    parameter int ADDR_W = 12
);
    logic              avalon_mm_slave_waitrequest;
    logic [1:0]        avalon_mm_slave_response;
    logic              avalon_mm_slave_readdatavalid;
    logic              avalon_mm_slave_writeresponsevalid;
    logic [31:0]       avalon_mm_slave_readdata;
    logic [ADDR_W-1:0] avalon_mm_slave_address;
    logic              avalon_mm_slave_read;
    logic              avalon_mm_slave_write;
    logic [3:0]        avalon_mm_slave_byteenable;
    logic [31:0]       avalon_mm_slave_writedata;

    modport master (
        input  avalon_mm_slave_waitrequest, avalon_mm_slave_response,
               avalon_mm_slave_readdatavalid, avalon_mm_slave_writeresponsevalid,
               avalon_mm_slave_readdata,
        output avalon_mm_slave_address, avalon_mm_slave_read, avalon_mm_slave_write,
               avalon_mm_slave_byteenable, avalon_mm_slave_writedata
    );

    modport slave (
        output avalon_mm_slave_waitrequest, avalon_mm_slave_response,
               avalon_mm_slave_readdatavalid, avalon_mm_slave_writeresponsevalid,
               avalon_mm_slave_readdata,
        input  avalon_mm_slave_address, avalon_mm_slave_read, avalon_mm_slave_write,
               avalon_mm_slave_byteenable, avalon_mm_slave_writedata
    );
endinterface

// File: rtl/agh_pwm_csr.sv
// Multi-channel PWM with double-buffered duty registers behind an Avalon-MM slave.
// Optional macro AGH_PWM_IRQ_EN adds CTRL.IE and a registered period-end interrupt.
module agh_pwm_csr #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    agh_pwm_csr_if.slave        s,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);
    localparam int WW = ADDR_W - 2;

    logic                en_q;
    logic                ie;
    logic [15:0]         prescale_q;
    logic [CNT_W-1:0]    period_q;
    logic                pend_q, pend_d;
    logic [CNT_W-1:0]    shadow_q [CHANNELS];
    logic [CNT_W-1:0]    active_q [CHANNELS];
    logic [15:0]         psc_q, psc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] pwm_q;
    logic                tick, wrap;

    logic                rd_vld_s1_q;
    logic [WW-1:0]       rd_word_s1_q;
    logic                rd_vld_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                wr_resp_q;

    logic [WW-1:0]       bus_word;
    logic                rd_req, wr_req, ctrl_wr, status_w1c;
    logic [31:0]         wr_cur, wr_merged;
    logic                unused_bits;

    assign bus_word   = s.avalon_mm_slave_address[ADDR_W-1:2];
    assign wr_req     = s.avalon_mm_slave_write;
    // An illegal simultaneous read+write performs the write only.
    assign rd_req     = s.avalon_mm_slave_read & ~s.avalon_mm_slave_write;
    assign ctrl_wr    = wr_req && (bus_word == WW'(0));
    assign status_w1c = wr_req && (bus_word == WW'(3)) &&
                        s.avalon_mm_slave_byteenable[0] && s.avalon_mm_slave_writedata[0];

    function automatic logic [31:0] reg_read(input logic [WW-1:0] w);
        logic [31:0] r;
        r = '0;
        case (w)
            WW'(0): r = {30'd0, ie, en_q};
            WW'(1): r = {16'd0, prescale_q};
            WW'(2): r[CNT_W-1:0] = period_q;
            WW'(3): r = {31'd0, pend_q};
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w == WW'(4 + i)) r[CNT_W-1:0] = shadow_q[i];
                end
            end
        endcase
        return r;
    endfunction

    // Byte-lane merge of write data over the current register contents.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_cur    = reg_read(bus_word);
        wr_merged = wr_cur;
        for (int b = 0; b < 4; b++) begin
            if (s.avalon_mm_slave_byteenable[b]) wr_merged[8*b +: 8] = s.avalon_mm_slave_writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
        if (!rst_n) begin
            en_q       <= 1'b0;
            prescale_q <= '0;
            period_q   <= '1;
            // NOTE: the duty array is reset like any other register: its reset value is software-visible.
            for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
        end else if (wr_req) begin
            if (ctrl_wr)                 en_q       <= wr_merged[0];
            if (bus_word == WW'(1))      prescale_q <= wr_merged[15:0];
            if (bus_word == WW'(2))      period_q   <= wr_merged[CNT_W-1:0];
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus_word == WW'(4 + i)) shadow_q[i] <= wr_merged[CNT_W-1:0];
            end
        end
    end

    assign tick = en_q && (psc_q == prescale_q);
    assign wrap = tick && (cnt_q >= period_q);

    always_comb begin
        psc_d  = psc_q + 16'd1;
        cnt_d  = cnt_q;
        pend_d = wrap | (pend_q & ~status_w1c);
        if (!en_q) begin
            psc_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            psc_d = '0;
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            pwm_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) active_q[i] <= '0;
        end else begin
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            for (int i = 0; i < CHANNELS; i++) begin
                // Active duty tracks its shadow while idle, otherwise only at the period boundary.
                if (!en_q || wrap) active_q[i] <= shadow_q[i];
                pwm_q[i] <= en_q && (cnt_q < active_q[i]);
            end
        end
    end

    assign rdata_d = reg_read(rd_word_s1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_s1_q  <= 1'b0;
            rd_word_s1_q <= '0;
            rd_vld_q     <= 1'b0;
            rdata_q      <= '0;
            wr_resp_q    <= 1'b0;
        end else begin
            rd_vld_s1_q  <= rd_req;
            rd_word_s1_q <= bus_word;
            rd_vld_q     <= rd_vld_s1_q;
            rdata_q      <= rd_vld_s1_q ? rdata_d : '0;
            wr_resp_q    <= wr_req;
        end
    end

`ifdef AGH_PWM_IRQ_EN
    logic ie_q, irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= wr_merged[1];
            irq_q <= pend_q & ie_q;
        end
    end

    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    assign s.avalon_mm_slave_waitrequest        = 1'b0;
    assign s.avalon_mm_slave_response           = 2'b00;
    assign s.avalon_mm_slave_readdatavalid      = rd_vld_q;
    assign s.avalon_mm_slave_writeresponsevalid = wr_resp_q;
    assign s.avalon_mm_slave_readdata           = rdata_q;
    assign pwm_out                              = pwm_q;

    assign unused_bits = ^{s.avalon_mm_slave_address[1:0], wr_merged[31:16], wr_merged[1], wr_cur[0]};
endmodule
